// File: rtl/dmem_pkg.sv
// Shared encodings and lane/extend helpers for the banked data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_RSV = 2'd3;

    typedef enum logic {INIT, RUN} state_e;

    // Context captured at acceptance and used to shape the response.
    typedef struct packed {
        logic       load;
        logic       err;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
    } rsp_ctx_t;

    function automatic logic access_err(logic [1:0] size, logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'd0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(logic [1:0] size, logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_rep(logic [1:0] size, logic [31:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(logic [31:0] word, logic [1:0] off,
                                             logic [1:0] size, logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_banked_if.sv
// Request/response handshake bundle between the load/store unit and the data memory.
interface dmem_banked_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// Single-port BANK_DEPTH x 32 RAM with byte write enables; read data only updates on reads.
module dmem_bank #(
    parameter int unsigned BANK_DEPTH = 1024
) (
    input  logic                          clk,
    input  logic                          en_i,
    input  logic [3:0]                    be_i,
    input  logic [$clog2(BANK_DEPTH)-1:0] addr_i,
    input  logic [31:0]                   wdata_i,
    output logic [31:0]                   rdata_o
);
    logic [31:0] mem_q [BANK_DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (|be_i) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_banked.sv
// Word-interleaved banked data memory with byte/half/word access, one response slot
// and a post-reset clear sweep over every row.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int unsigned NUM_BANKS  = 8,
    parameter int unsigned BANK_DEPTH = 1024,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic          clk,
    input  logic          reset,
    dmem_banked_if.slave  bus,
    output logic          init_done
);
    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned ROW_W  = $clog2(BANK_DEPTH);

    state_e                            state_q, state_d;
    logic [ROW_W-1:0]                  cnt_q, cnt_d;
    logic                              init_done_q, init_done_d;
    logic                              rsp_valid_q, rsp_valid_d;
    rsp_ctx_t                          ctx_q, ctx_d;
    logic [BANK_W-1:0]                 bank_q, bank_d;

    logic [1:0]                        req_off;
    logic [BANK_W-1:0]                 req_bank;
    logic [ROW_W-1:0]                  req_row;
    logic                              req_err_c;
    logic                              req_ready_c;
    logic                              acc_c;

    logic [NUM_BANKS-1:0]              bank_en;
    logic [NUM_BANKS-1:0][3:0]         bank_be;
    logic [ROW_W-1:0]                  bank_addr;
    logic [31:0]                       bank_wdata;
    logic [NUM_BANKS-1:0][31:0]        bank_rdata;

    assign req_off   = bus.req_addr[1:0];
    assign req_bank  = bus.req_addr[2 +: BANK_W];
    assign req_row   = bus.req_addr[ADDR_W-1 -: ROW_W];
    assign req_err_c = access_err(bus.req_size, req_off);

    // Single response slot: accept when empty or being drained this cycle.
    assign req_ready_c = !reset && (state_q == RUN) && (!rsp_valid_q || bus.rsp_ready);
    assign acc_c       = bus.req_valid && req_ready_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            ctx_q       <= '0;
            bank_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            ctx_q       <= ctx_d;
            bank_q      <= bank_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        ctx_d       = ctx_q;
        bank_d      = bank_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + ROW_W'(1);
                if (cnt_q == ROW_W'(BANK_DEPTH - 1)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (acc_c) begin
                    rsp_valid_d = 1'b1;
                    ctx_d.load  = !bus.req_we && !req_err_c;
                    ctx_d.err   = req_err_c;
                    ctx_d.size  = bus.req_size;
                    ctx_d.uns   = bus.req_unsigned;
                    ctx_d.off   = req_off;
                    bank_d      = req_bank;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Bank controls: all banks clear the same row during INIT, otherwise only the addressed bank.
    always_comb begin
        bank_en    = '0;
        bank_be    = '0;
        bank_addr  = req_row;
        bank_wdata = store_rep(bus.req_size, bus.req_wdata);
        if (state_q == INIT) begin
            bank_en    = '1;
            bank_addr  = cnt_q;
            bank_wdata = '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) bank_be[b] = 4'hF;
        end else if (acc_c && !req_err_c) begin
            bank_en[req_bank] = 1'b1;
            if (bus.req_we) bank_be[req_bank] = lane_be(bus.req_size, req_off);
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        dmem_bank #(.BANK_DEPTH(BANK_DEPTH)) u_bank (
            .clk     (clk),
            .en_i    (bank_en[g]),
            .be_i    (bank_be[g]),
            .addr_i  (bank_addr),
            .wdata_i (bank_wdata),
            .rdata_o (bank_rdata[g])
        );
    end

    // Bank read data is held while stalled, so lane select/extend can stay after the RAM.
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_valid_q && ctx_q.err;
    assign bus.rsp_rdata = (rsp_valid_q && ctx_q.load)
                         ? load_ext(bank_rdata[bank_q], ctx_q.off, ctx_q.size, ctx_q.uns)
                         : 32'd0;
    assign init_done     = init_done_q;
endmodule

// File: tb/tb_dmem_banked.sv
// Bench for dmem_banked: byte-addressed reference memory plus an in-order response queue.
module tb_dmem_banked;
    import dmem_pkg::*;

    localparam int unsigned AW = 15;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic init_done;
    always #5 clk = ~clk;

    dmem_banked_if #(.ADDR_W(AW)) bus();

    dmem_banked #(.NUM_BANKS(8), .BANK_DEPTH(1024), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .init_done (init_done)
    );

    logic [7:0] mm [1 << AW];
    exp_t       expq[$];
    int         n_cmp = 0;
    int         n_mis = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: byte-addressed little-endian memory, extension by arithmetic.
    function automatic exp_t model(logic we, logic [AW-1:0] a, logic [1:0] sz,
                                   logic uns, logic [31:0] wd);
        exp_t r;
        int   nb;
        int   v;
        r.err   = 1'b0;
        r.rdata = 32'd0;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd3 || (int'(a) % nb) != 0) begin
            r.err = 1'b1;
            return r;
        end
        if (we) begin
            for (int i = 0; i < nb; i++) mm[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v | (int'(mm[int'(a) + i]) << (8*i));
            if (!uns && nb < 4 && v >= (1 << (8*nb - 1))) v = v - (1 << (8*nb));
            r.rdata = 32'(v);
        end
        return r;
    endfunction

    task automatic drive_idle();
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = '0;
        bus.req_size     = SZ_W;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b0;
    endtask

    // One clock: check outputs against the model, drive, predict handshakes, advance.
    task automatic cycle(logic v, logic we, logic [AW-1:0] a, logic [1:0] sz, logic uns,
                         logic [31:0] wd, logic rr, output logic acc);
        logic exp_rdy;
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(expq.size() != 0));
        if (expq.size() != 0 && bus.rsp_valid === 1'b1) begin
            check_eq("rsp_err", 32'(bus.rsp_err), 32'(expq[0].err));
            check_eq("rsp_rdata", bus.rsp_rdata, expq[0].rdata);
        end
        bus.req_valid    = v;
        bus.req_we       = we;
        bus.req_addr     = a;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_wdata    = wd;
        bus.rsp_ready    = rr;
        #1;
        exp_rdy = (expq.size() == 0) || rr;
        check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        if (expq.size() != 0 && rr) void'(expq.pop_front());
        if (acc) expq.push_back(model(we, a, sz, uns, wd));
        @(negedge clk);
    endtask

    task automatic issue(logic we, logic [AW-1:0] a, logic [1:0] sz, logic uns, logic [31:0] wd);
        logic acc;
        cycle(1'b1, we, a, sz, uns, wd, 1'b1, acc);
        check_eq("accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        logic acc;
        cycle(1'b0, 1'b0, '0, SZ_W, 1'b0, 32'd0, 1'b1, acc);
    endtask

    task automatic load_lit(string tag, logic [AW-1:0] a, logic [1:0] sz, logic uns,
                            logic [31:0] lit);
        issue(1'b0, a, sz, uns, 32'd0);
        check_eq(tag, bus.rsp_rdata, lit);
        check_eq({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
        drain();
    endtask

    task automatic err_lit(string tag, logic we, logic [AW-1:0] a, logic [1:0] sz,
                           logic [31:0] wd);
        issue(we, a, sz, 1'b0, wd);
        check_eq(tag, 32'(bus.rsp_err), 32'd1);
        check_eq({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
        drain();
    endtask

    task automatic do_reset();
        int   k;
        logic rdy_seen;
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_init_done", 32'(init_done), 32'd0);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        for (int i = 0; i < (1 << AW); i++) mm[i] = 8'd0;
        expq.delete();
        reset    = 1'b0;
        rdy_seen = 1'b0;
        k        = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (init_done === 1'b1) begin
                k = c;
                break;
            end
            if (bus.req_ready !== 1'b0) rdy_seen = 1'b1;
        end
        check_eq("init_cycles", 32'(k), 32'd1024);
        check_eq("ready_during_init", 32'(rdy_seen), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic acc;
        int   idx;
        int   c;
        logic [AW-1:0] a;
        logic [1:0]    sz;

        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        do_reset();

        load_lit("cleared_word", 15'h1F0C, SZ_W, 1'b0, 32'h0000_0000);

        issue(1'b1, 15'h0040, SZ_W, 1'b0, 32'hDEAD_BEEF);
        drain();
        load_lit("lb_43",  15'h0043, SZ_B, 1'b0, 32'hFFFF_FFDE);
        load_lit("lbu_43", 15'h0043, SZ_B, 1'b1, 32'h0000_00DE);
        load_lit("lh_40",  15'h0040, SZ_H, 1'b0, 32'hFFFF_BEEF);
        load_lit("lhu_42", 15'h0042, SZ_H, 1'b1, 32'h0000_DEAD);
        issue(1'b1, 15'h0041, SZ_B, 1'b0, 32'h0000_005A);
        load_lit("lw_after_sb", 15'h0040, SZ_W, 1'b0, 32'hDEAD_5AEF);

        issue(1'b1, 15'h0000, SZ_W, 1'b0, 32'hCAFE_F00D);
        err_lit("lw_mis",  1'b0, 15'h0002, SZ_W,   32'd0);
        err_lit("sh_mis",  1'b1, 15'h0001, SZ_H,   32'h0000_1234);
        err_lit("sz3_st",  1'b1, 15'h0000, SZ_RSV, 32'h1111_1111);
        load_lit("mem_unchanged", 15'h0000, SZ_W, 1'b0, 32'hCAFE_F00D);

        // Back-to-back loads across banks 0..3 with the consumer stalled for 3 cycles.
        for (int i = 0; i < 4; i++) issue(1'b1, AW'(i * 4), SZ_W, 1'b0, 32'hA5A5_0000 + 32'(i));
        drain();
        idx = 0;
        c   = 0;
        while (c < 40 && (idx < 4 || expq.size() != 0)) begin
            cycle(idx < 4, 1'b0, AW'(idx * 4), SZ_W, 1'b0, 32'd0, c >= 3, acc);
            if (acc) idx++;
            c++;
        end
        check_eq("burst_accepts", 32'(idx), 32'd4);
        check_eq("burst_drained", 32'(expq.size()), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            sz = ($urandom_range(0, 9) == 0) ? SZ_RSV : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 127));
            if ($urandom_range(0, 4) != 0) begin
                if (sz == SZ_H) a[0] = 1'b0;
                else if (sz == SZ_W) a[1:0] = 2'b00;
            end
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, sz,
                  1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0, acc);
        end
        for (int n = 0; n < 4 && expq.size() != 0; n++) drain();
        check_eq("random_drained", 32'(expq.size()), 32'd0);

        issue(1'b1, 15'h0100, SZ_W, 1'b0, 32'h1234_5678);
        drain();
        cycle(1'b1, 1'b0, 15'h0100, SZ_W, 1'b0, 32'd0, 1'b0, acc);
        check_eq("pending_before_rst", 32'(bus.rsp_valid), 32'd1);
        check_eq("pending_data", bus.rsp_rdata, 32'h1234_5678);
        do_reset();
        load_lit("cleared_after_rst", 15'h0100, SZ_W, 1'b0, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
